// File: rtl/sequencer_pattern_player_pkg.sv
// Shared transport states, tempo table and period helper for the pattern player.
package sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAUSED  = 2'd1,
    RUNNING = 2'd2
  } seq_state_t;

  localparam int NUM_TEMPOS = 4;
  localparam int unsigned SYS_CLK_HZ = 10000;

  typedef logic [1:0] tempo_idx_t;

  localparam int unsigned TEMPO_BPM    [NUM_TEMPOS] = '{60, 90, 120, 150};
  localparam int unsigned TEMPO_PERIOD [NUM_TEMPOS] = '{10000, 6667, 5000, 4000};

  // Nominal clock uses the fixed table; other clocks round to the nearest cycle.
  function automatic int unsigned tempo_period(input int unsigned clk_hz, input tempo_idx_t idx);
    if (clk_hz == SYS_CLK_HZ) return TEMPO_PERIOD[idx];
    return (clk_hz * 60 + TEMPO_BPM[idx] / 2) / TEMPO_BPM[idx];
  endfunction

endpackage

// File: rtl/sequencer_pattern_player_tempo_timer.sv
// Beat-period timer: tempo selection, period lookup and the per-beat counter.
module sequencer_tempo_timer
  import sequencer_pkg::*;
#(
  parameter int CLK_HZ = 10000,
  parameter int CNT_W  = 14
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tempo_button,
  input  logic       run,
  input  logic       clear,
  output tempo_idx_t tempo_sel,
  output logic       wrap,
  output logic       half_period
);

  localparam logic [CNT_W-1:0] PERIOD_LUT [NUM_TEMPOS] = '{
    CNT_W'(tempo_period(CLK_HZ, tempo_idx_t'(0))),
    CNT_W'(tempo_period(CLK_HZ, tempo_idx_t'(1))),
    CNT_W'(tempo_period(CLK_HZ, tempo_idx_t'(2))),
    CNT_W'(tempo_period(CLK_HZ, tempo_idx_t'(3)))
  };

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] period;

  assign period = PERIOD_LUT[tempo_sel];

  // >= so a switch to a shorter period mid-beat wraps next cycle instead of overrunning.
  assign wrap        = (count >= (period - CNT_W'(1)));
  assign half_period = (count < (period >> 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tempo_sel <= '0;
      count     <= '0;
    end else begin
      if (tempo_button) tempo_sel <= tempo_sel + 2'd1;
      if (clear) begin
        count <= '0;
      end else if (run) begin
        count <= wrap ? '0 : count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sequencer_pattern_player.sv
// Step-pattern player: pattern edit, step position and transport FSM feeding the tone path.
// state   | meaning
// IDLE    | piano mode; step and count forced to zero
// PAUSED  | sequencer mode, transport stopped; step and count held
// RUNNING | sequencer mode, stepping at the selected tempo
module sequencer_pattern_player
  import sequencer_pkg::*;
#(
  parameter int NUM_BEATS = 8,
  parameter int CLK_HZ    = 10000,
  parameter int CNT_W     = 14
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [NUM_BEATS-1:0]         toggle,
  input  logic                         sequencer_on,
  input  logic                         play,
  input  logic                         tempo_button,
  output logic [NUM_BEATS-1:0]         pattern,
  output logic [$clog2(NUM_BEATS)-1:0] beat_idx,
  output logic                         beat_strobe,
  output logic                         note_gate,
  output logic [1:0]                   tempo_sel
);

  localparam int BIDX_W = $clog2(NUM_BEATS);

  seq_state_t state;
  seq_state_t next_state;
  logic       run_en;
  logic       clear;
  logic       wrap;
  logic       half_period;

  always_comb begin
    next_state = RUNNING;
    if (!sequencer_on) next_state = IDLE;
    else if (!play)    next_state = PAUSED;
  end

  // Leaving IDLE starts from a clean count, and dropping play holds the count that same cycle.
  assign run_en = (state != IDLE) && (next_state == RUNNING);
  assign clear  = (next_state == IDLE);

  sequencer_tempo_timer #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) u_tempo_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .tempo_button (tempo_button),
    .run          (run_en),
    .clear        (clear),
    .tempo_sel    (tempo_sel),
    .wrap         (wrap),
    .half_period  (half_period)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      pattern     <= '0;
      beat_idx    <= '0;
      beat_strobe <= 1'b0;
    end else begin
      state       <= next_state;
      beat_strobe <= 1'b0;
      if (sequencer_on) pattern <= pattern ^ toggle;
      if (next_state == IDLE) begin
        beat_idx <= '0;
      end else if (run_en && wrap) begin
        beat_idx    <= beat_idx + BIDX_W'(1);
        beat_strobe <= 1'b1;
      end
    end
  end

  assign note_gate = (state == RUNNING) && pattern[beat_idx] && half_period;

endmodule

// File: doc/sequencer_pattern_player.md
Name: sequencer_pattern_player

Overview:
Consumes the debounced, edge-detected control outputs of the sequencer key front end: beat toggles, sequencer_on level, play level and tempo pulse. Holds an 8-step on/off pattern and steps through it at one of four tempos. Drives the beat position and a note gate to the audio/tone path. Sits between the key encoder and the oscillator/output mixer on the 10 kHz system clock.

Parameters:
NUM_BEATS, 8, steps per measure; must be a power of 2.
CLK_HZ, 10000, system clock frequency used to derive beat periods.
CNT_W, 14, width of the beat-period counter; must hold the largest period.

Ports:
clk  in  1  system clock, 10 kHz
n_rst  in  1  asynchronous active-low reset
toggle  in  NUM_BEATS  one-cycle pulses; bit i flips pattern step i
sequencer_on  in  1  level; 1 = sequencer mode, 0 = piano mode
play  in  1  level; 1 = run, 0 = pause
tempo_button  in  1  one-cycle pulse; advance tempo selection
pattern  out  NUM_BEATS  current step pattern
beat_idx  out  $clog2(NUM_BEATS)  current step
beat_strobe  out  1  one-cycle pulse on each step advance
note_gate  out  1  high while the current step is sounding
tempo_sel  out  2  current tempo index

Behaviour:
- Reset (n_rst=0, asynchronous): pattern=0, beat_idx=0, count=0, tempo_sel=0, state=IDLE, beat_strobe=0, note_gate=0.
- Tempo LUT (period in cycles = CLK_HZ*60/BPM):
  - idx0: 60 BPM, 10000 cycles
  - idx1: 90 BPM, 6667 cycles
  - idx2: 120 BPM, 5000 cycles
  - idx3: 150 BPM, 4000 cycles
- tempo_button pulse: tempo_sel <= tempo_sel+1, wrapping 3->0. Accepted in all states. Takes effect on the next cycle's compare.
- Pattern edit:
  - When sequencer_on=1: pattern <= pattern ^ toggle, one cycle latency. Multiple bits in one cycle all apply.
  - When sequencer_on=0: toggles are ignored and pattern is retained.
- Next state is computed from the current-cycle inputs:
  - IDLE: entered whenever sequencer_on=0. Forces beat_idx=0 and count=0.
  - PAUSED: sequencer_on=1 and play=0. Holds beat_idx and count.
  - RUNNING: sequencer_on=1 and play=1.
  - IDLE->RUNNING starts at step 0, count 0.
  - PAUSED->RUNNING resumes from the held count.
  - Any state->IDLE is taken in one cycle, including mid-beat.
- RUNNING counting:
  - Each cycle, if count >= period-1: count <= 0, beat_idx <= beat_idx+1 (wrapping NUM_BEATS-1 -> 0), beat_strobe=1 for that cycle (registered).
  - Otherwise count <= count+1.
  - The >= compare covers a tempo change to a shorter period mid-beat: the step advances on the next cycle.
- note_gate = (state==RUNNING) & pattern[beat_idx] & (count < period>>1), i.e. a 50% duty gate. It is combinational from registers; no input feeds note_gate directly.
- Toggling the current step while RUNNING affects note_gate on the next cycle.
- beat_strobe is never asserted in IDLE or PAUSED.

Decomposition:
- Shared package sequencer_pkg holds:
  - state enum {IDLE, PAUSED, RUNNING}
  - NUM_TEMPOS=4
  - TEMPO_PERIOD constant array
  - tempo index typedef
- One sub-module, sequencer_tempo_timer: owns tempo_sel, the LUT, count and the wrap compare. Outputs wrap and half_period flags.
- Pattern register, beat_idx and the FSM stay in the top module.

Test Plan:
- Reset with sequencer_on=1, play=1 held -> first cycle after release: state RUNNING, beat_idx=0. At tempo 0, beat_strobe is first seen 10000 cycles later and beat_idx=1.
- pattern=8'b0000_0101, RUNNING at tempo 3 -> note_gate high for 2000 cycles, low for 2000 on step 0. Low for all of step 1. beat_idx wraps 7->0 after 32000 cycles.
- Pause at step 3, count 1234; hold 500 cycles; resume -> beat_idx stays 3, count resumes from 1234, next strobe 2765 cycles after resume.
- tempo_button at count 6000 under tempo 0 (10000->6667) -> no early wrap. Press again to idx2 (5000) at count 6000 -> strobe on the next cycle and count=0.
- toggle=8'hFF pulse with sequencer_on=0 -> pattern unchanged. Same pulse with sequencer_on=1 -> pattern inverted one cycle later. Dropping sequencer_on mid-beat -> IDLE, beat_idx=0, note_gate=0 next cycle.
- Assert n_rst low mid-RUNNING, asynchronously between edges -> all outputs zero immediately, tempo_sel=0.
